hub75e_rx: RTL and testbench
============================

# hub75e_rx

Receiving end of the HUB75E panel interface: a synchronous capture engine that oversamples the CK/ST/OE/address/RGB pins driven by the panel driver and reconstructs each latched row. Output is a stream of per-column pixel beats with row address and on-time. It sits in the bench/loopback path, and optionally on a second board, to check the driver and frame-buffer contents against what a real panel would display.

## Interface
Parameters:
- COLS, 64, shifted columns per row (2..255)
- ADDR_W, 5, row-address width (E,D,C,B,A)

Ports:
- clk  in  1  capture clock; must be ≥4× hub_ck toggle rate
- resetn  in  1  synchronous, active-low
- hub_ck  in  1  panel shift clock, asynchronous
- hub_st  in  1  panel latch strobe, asynchronous
- hub_oe  in  1  panel output enable, active-low
- hub_addr  in  ADDR_W  row select {E,D,C,B,A}
- hub_rgb  in  6  {R2,G2,B2,R1,G1,B1}
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_row  out  ADDR_W  row address latched with this row
- out_col  out  8  column index, 0..COLS-1
- out_rgb  out  6  pixel bits for out_col
- out_last  out  1  high on column COLS-1 beat
- out_col_err  out  1  shifted-column count at latch ≠ COLS
- out_on_cycles  out  16  clk cycles OE was active (low) during the previous row period
- overrun  out  1  sticky: ST arrived while a row was still streaming

## Operation
- Synchronizer: hub_ck, hub_st, hub_oe, hub_addr, hub_rgb all pass through identical 2-flop chains, so data stays aligned with its strobe. A third register on ck/st provides rising-edge detect (ck_rise, st_rise).
- Shift: on ck_rise, the synced hub_rgb is pushed into a COLS×6 shift register. Shift order is column index: the first word after the previous latch becomes column 0. If more than COLS words arrive, the oldest are discarded and the last COLS words are kept. col_cnt (8 bit) increments per ck_rise and saturates at 255.
- OE meter: on_cnt (16 bit, saturating at 0xFFFF) increments each cycle synced hub_oe==0.
- Latch, on st_rise:
  - IDLE state: row buffer ← shift register, including any same-cycle ck_rise word. Capture row ← synced hub_addr, err ← (col_cnt_next ≠ COLS), on ← on_cnt. Go to STREAM.
  - STREAM state: latch is dropped and overrun ← 1 (sticky until reset).
  - In both states, col_cnt and on_cnt restart from 0; a same-cycle ck_rise counts as 1 and a same-cycle OE-active cycle counts as 1.
- Stream FSM:
  - IDLE: out_valid=0.
  - STREAM: out_valid=1 with beat index i. On out_valid&out_ready, i++. On the beat where i==COLS-1 (out_last=1), go to IDLE and set i←0.
  - out_row, out_col_err, out_on_cycles are constant for all beats of a row. out_col=i, out_rgb=rowbuf[i].
- Valid-ready rule: outputs hold stable while out_valid&!out_ready. Valid never drops without acceptance except on reset.
- Shift register, counters and OE meter keep running in both states. Capture is never stalled by the consumer.

## Timing
- Pin to edge detect: 3 clk (2 sync + edge register).
- st_rise in cycle N → out_valid=1 with out_col=0 in cycle N+1.
- Full-throughput row: COLS cycles with out_ready held high. The next row can latch in the cycle after the out_last acceptance.
- st_rise in the same cycle as the final beat's acceptance counts as STREAM and raises overrun.
- Minimum hub_ck high and low: 2 clk each. Narrower pulses may be missed; that is not detected.
- Reset, including mid-stream: the next cycle has FSM=IDLE, i=0, and out_valid, out_last, out_col_err, overrun, out_row, out_col, out_rgb, out_on_cycles all 0. col_cnt, on_cnt, sync flops and shift register also clear to 0.

## Test plan
- Row 5, rgb=col[5:0] for 64 CK pulses, then ST, out_ready=1: 64 consecutive beats, out_col 0..63, out_rgb=out_col[5:0], out_row=5, out_last only on col 63, out_col_err=0.
- 63 CKs then ST: 64 beats, out_col_err=1. 70 CKs (values 0..69) then ST: out_rgb cols 0..63 = 6..69 mod 64, err=1.
- out_ready pseudo-random 50%: exactly 64 accepted beats, in order, no duplicates, signals stable while stalled.
- Second ST after 10 accepted beats with out_ready low: overrun=1 and stays 1. The first row's remaining 54 beats are unchanged. No second row is emitted.
- OE held low 100 clk between two STs: second row's out_on_cycles=100. OE never low: out_on_cycles=0.
- resetn low for 1 cycle at beat 30: next cycle out_valid=0 and overrun=0. A fresh row afterwards streams from out_col=0.

Source files
------------

// File: rtl/hub75e_rx.sv
// hub75e_rx: HUB75E receive/capture engine. Oversamples the panel pins,
// rebuilds each latched row and streams it out as per-column beats.
module hub75e_rx #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hub_ck,
    input  logic              hub_st,
    input  logic              hub_oe,
    input  logic [ADDR_W-1:0] hub_addr,
    input  logic [5:0]        hub_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_row,
    output logic [7:0]        out_col,
    output logic [5:0]        out_rgb,
    output logic              out_last,
    output logic              out_col_err,
    output logic [15:0]       out_on_cycles,
    output logic              overrun
);

    localparam logic [7:0] COLS8 = 8'(COLS);
    localparam logic [7:0] LAST8 = 8'(COLS - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;
    state_t state;

    logic [2:0]        ck_sync;
    logic [2:0]        st_sync;
    logic [1:0]        oe_sync;
    logic [ADDR_W-1:0] addr_s1, addr_s2;
    logic [5:0]        rgb_s1, rgb_s2;

    logic [5:0]  shreg      [COLS];
    logic [5:0]  shreg_next [COLS];
    logic [5:0]  rowbuf     [COLS];
    logic [7:0]  col_cnt;
    logic [7:0]  col_cnt_next;
    logic [15:0] on_cnt;
    logic [7:0]  nxt;
    logic [5:0]  beat_next;

    logic ck_rise, st_rise, oe_act;

    assign ck_rise = ck_sync[1] & ~ck_sync[2];
    assign st_rise = st_sync[1] & ~st_sync[2];
    assign oe_act  = ~oe_sync[1];
    assign nxt     = out_col + 8'd1;
    assign col_cnt_next = (ck_rise && col_cnt != 8'hFF) ? col_cnt + 8'd1 : col_cnt;

    // Two-flop synchronizers on every pin, plus an edge register on ck/st
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ck_sync <= '0;
            st_sync <= '0;
            oe_sync <= '0;
            addr_s1 <= '0;
            addr_s2 <= '0;
            rgb_s1  <= '0;
            rgb_s2  <= '0;
        end else begin
            ck_sync <= {ck_sync[1:0], hub_ck};
            st_sync <= {st_sync[1:0], hub_st};
            oe_sync <= {oe_sync[0], hub_oe};
            addr_s1 <= hub_addr;
            addr_s2 <= addr_s1;
            rgb_s1  <= hub_rgb;
            rgb_s2  <= rgb_s1;
        end
    end

    // Next shift-register contents: newest word enters at the top, column 0 is the oldest kept
    always_comb begin
        shreg_next = shreg;
        if (ck_rise) begin
            for (int unsigned k = 0; k < COLS - 1; k++) begin
                shreg_next[k] = shreg[k+1];
            end
            shreg_next[COLS-1] = rgb_s2;
        end
    end

    // Row-buffer read for the beat following the current one
    always_comb begin
        beat_next = '0;
        for (int unsigned k = 0; k < COLS; k++) begin
            if (8'(k) == nxt) beat_next = rowbuf[k];
        end
    end

    // Column shift register
    always_ff @(posedge clk) begin
        if (!resetn) shreg <= '{default: '0};
        else         shreg <= shreg_next;
    end

    // Column counter and OE on-time meter; both restart on every latch strobe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_cnt <= '0;
            on_cnt  <= '0;
        end else if (st_rise) begin
            col_cnt <= ck_rise ? 8'd1 : 8'd0;
            on_cnt  <= oe_act ? 16'd1 : 16'd0;
        end else begin
            col_cnt <= col_cnt_next;
            if (oe_act && on_cnt != 16'hFFFF) on_cnt <= on_cnt + 16'd1;
        end
    end

    // Latch/stream FSM with registered beat outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            rowbuf        <= '{default: '0};
            out_valid     <= 1'b0;
            out_row       <= '0;
            out_col       <= '0;
            out_rgb       <= '0;
            out_last      <= 1'b0;
            out_col_err   <= 1'b0;
            out_on_cycles <= '0;
            overrun       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (st_rise) begin
                        rowbuf        <= shreg_next;
                        out_row       <= addr_s2;
                        out_col_err   <= (col_cnt_next != COLS8);
                        out_on_cycles <= on_cnt;
                        out_col       <= '0;
                        out_rgb       <= shreg_next[0];
                        out_last      <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (st_rise) overrun <= 1'b1;
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_col   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_col  <= nxt;
                            out_rgb  <= beat_next;
                            out_last <= (nxt == LAST8);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75e_rx.sv
// tb_hub75e_rx: directed self-checking bench for hub75e_rx.
module tb_hub75e_rx;

    localparam int COLS   = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              hub_ck = 1'b0;
    logic              hub_st = 1'b0;
    logic              hub_oe = 1'b1;
    logic [ADDR_W-1:0] hub_addr = '0;
    logic [5:0]        hub_rgb = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_row;
    logic [7:0]        out_col;
    logic [5:0]        out_rgb;
    logic              out_last;
    logic              out_col_err;
    logic [15:0]       out_on_cycles;
    logic              overrun;

    hub75e_rx #(.COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .hub_ck(hub_ck), .hub_st(hub_st), .hub_oe(hub_oe),
        .hub_addr(hub_addr), .hub_rgb(hub_rgb), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_rgb(out_rgb), .out_last(out_last),
        .out_col_err(out_col_err), .out_on_cycles(out_on_cycles), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]        g_col  [256];
    logic [5:0]        g_rgb  [256];
    logic              g_last [256];
    logic [ADDR_W-1:0] g_row  [256];
    logic              g_err  [256];
    logic [15:0]       g_on   [256];
    int                g_cyc  [256];
    int                n;
    int                stall_err;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [5:0] d);
        @(negedge clk) hub_rgb = d;
        @(negedge clk) hub_ck = 1'b1;
        repeat (3) @(negedge clk);
        hub_ck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_st();
        @(negedge clk) hub_st = 1'b1;
        repeat (3) @(negedge clk);
        hub_st = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Consumer: records accepted beats; mode 0 = always ready, 1 = random ready.
    // Stops after out_last, after stop_after beats (0 = no limit) or after max_cyc cycles.
    task automatic collect(input int mode, input int stop_after, input int max_cyc);
        logic              pv;
        logic [7:0]        pc;
        logic [5:0]        pr;
        logic              pl;
        logic [ADDR_W-1:0] prow;
        logic              done;
        pv = 1'b0; pc = '0; pr = '0; pl = 1'b0; prow = '0; done = 1'b0;
        n = 0;
        stall_err = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (pv && (out_valid !== 1'b1 || out_col !== pc || out_rgb !== pr ||
                       out_last !== pl || out_row !== prow))
                stall_err++;
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
            if (out_valid === 1'b1 && out_ready && n < 256) begin
                g_col[n] = out_col; g_rgb[n] = out_rgb; g_last[n] = out_last;
                g_row[n] = out_row; g_err[n] = out_col_err; g_on[n] = out_on_cycles;
                g_cyc[n] = cyc;
                n++;
                if (out_last === 1'b1 || n == stop_after) done = 1'b1;
            end
            pv = (out_valid === 1'b1) && !out_ready;
            pc = out_col; pr = out_rgb; pl = out_last; prow = out_row;
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
        checks++; if (out_col !== 8'd0) begin errors++; $display("FAIL reset_col got %0d exp 0", out_col); end
        checks++; if (out_rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb got %0d exp 0", out_rgb); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b exp 0", out_last); end
        checks++; if (out_row !== '0) begin errors++; $display("FAIL reset_row got %0d exp 0", out_row); end
        checks++; if (out_col_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", out_col_err); end
        checks++; if (out_on_cycles !== 16'd0) begin errors++; $display("FAIL reset_on got %0d exp 0", out_on_cycles); end
    endtask

    task automatic test_basic_row();
        hub_addr = 5'd5;
        for (int c = 0; c < 64; c++) send_word(6'(c));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL basic_count got %0d exp 64", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g_col[k] !== 8'(k)) begin errors++; $display("FAIL basic_col[%0d] got %0d exp %0d", k, g_col[k], k); end
            checks++; if (g_rgb[k] !== 6'(k)) begin errors++; $display("FAIL basic_rgb[%0d] got %0d exp %0d", k, g_rgb[k], k); end
            checks++; if (g_last[k] !== (k == 63)) begin errors++; $display("FAIL basic_last[%0d] got %0b exp %0b", k, g_last[k], k == 63); end
            checks++; if (g_row[k] !== 5'd5) begin errors++; $display("FAIL basic_row[%0d] got %0d exp 5", k, g_row[k]); end
            checks++; if (g_err[k] !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got %0b exp 0", k, g_err[k]); end
        end
        if (n == 64) begin
            checks++; if (g_cyc[63] - g_cyc[0] != 63) begin errors++; $display("FAIL basic_throughput got %0d exp 63", g_cyc[63] - g_cyc[0]); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after got %0b exp 0", out_valid); end
    endtask

    task automatic test_col_err();
        hub_addr = 5'd9;
        for (int c = 0; c < 63; c++) send_word(6'(c));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL short_count got %0d exp 64", n); end
        checks++; if (g_err[0] !== 1'b1) begin errors++; $display("FAIL short_err got %0b exp 1", g_err[0]); end
        checks++; if (g_row[0] !== 5'd9) begin errors++; $display("FAIL short_row got %0d exp 9", g_row[0]); end

        hub_addr = 5'd11;
        for (int c = 0; c < 70; c++) send_word(6'(c % 64));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL long_count got %0d exp 64", n); end
        checks++; if (g_err[0] !== 1'b1) begin errors++; $display("FAIL long_err got %0b exp 1", g_err[0]); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g_rgb[k] !== 6'((k + 6) % 64)) begin errors++; $display("FAIL long_rgb[%0d] got %0d exp %0d", k, g_rgb[k], (k + 6) % 64); end
        end
    endtask

    task automatic test_backpressure();
        hub_addr = 5'd17;
        for (int c = 0; c < 64; c++) send_word(6'(63 - c));
        send_st();
        collect(1, 0, 2000);
        checks++; if (n != 64) begin errors++; $display("FAIL bp_count got %0d exp 64", n); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stall_err); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g_col[k] !== 8'(k)) begin errors++; $display("FAIL bp_col[%0d] got %0d exp %0d", k, g_col[k], k); end
            checks++; if (g_rgb[k] !== 6'(63 - k)) begin errors++; $display("FAIL bp_rgb[%0d] got %0d exp %0d", k, g_rgb[k], 63 - k); end
        end
        checks++; if (g_on[0] !== 16'd0) begin errors++; $display("FAIL oe_never_low got %0d exp 0", g_on[0]); end
    endtask

    task automatic test_overrun();
        int seen;
        hub_addr = 5'd3;
        for (int c = 0; c < 64; c++) send_word(6'(c) ^ 6'h2A);
        send_st();
        collect(0, 10, 300);
        checks++; if (n != 10) begin errors++; $display("FAIL ovr_first_count got %0d exp 10", n); end
        hub_addr = 5'd7;
        send_st();
        repeat (3) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0b exp 1", overrun); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid got %0b exp 1", out_valid); end
        checks++; if (out_col !== 8'd10) begin errors++; $display("FAIL ovr_hold_col got %0d exp 10", out_col); end
        collect(0, 0, 300);
        checks++; if (n != 54) begin errors++; $display("FAIL ovr_rest_count got %0d exp 54", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g_col[k] !== 8'(k + 10)) begin errors++; $display("FAIL ovr_col[%0d] got %0d exp %0d", k, g_col[k], k + 10); end
            checks++; if (g_rgb[k] !== (6'(k + 10) ^ 6'h2A)) begin errors++; $display("FAIL ovr_rgb[%0d] got %0d exp %0d", k, g_rgb[k], 6'(k + 10) ^ 6'h2A); end
            checks++; if (g_row[k] !== 5'd3) begin errors++; $display("FAIL ovr_row[%0d] got %0d exp 3", k, g_row[k]); end
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL ovr_no_second_row got %0d valid cycles exp 0", seen); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", overrun); end
    endtask

    task automatic test_oe_meter();
        hub_addr = 5'd21;
        for (int c = 0; c < 64; c++) send_word(6'(c));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL oe_rowA_count got %0d exp 64", n); end
        @(negedge clk) hub_oe = 1'b0;
        repeat (100) @(negedge clk);
        hub_oe = 1'b1;
        hub_addr = 5'd22;
        for (int c = 0; c < 64; c++) send_word(6'(c));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL oe_rowB_count got %0d exp 64", n); end
        checks++; if (g_on[0] !== 16'd100) begin errors++; $display("FAIL oe_on_cycles got %0d exp 100", g_on[0]); end
        checks++; if (g_on[63] !== 16'd100) begin errors++; $display("FAIL oe_on_const got %0d exp 100", g_on[63]); end
    endtask

    task automatic test_reset_midstream();
        hub_addr = 5'd12;
        for (int c = 0; c < 64; c++) send_word(6'(c));
        send_st();
        collect(0, 30, 300);
        checks++; if (n != 30) begin errors++; $display("FAIL rst_pre_count got %0d exp 30", n); end
        checks++; if (out_col !== 8'd30) begin errors++; $display("FAIL rst_beat30 got %0d exp 30", out_col); end
        @(negedge clk) resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b exp 0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %0b exp 0", overrun); end
        checks++; if (out_col !== 8'd0) begin errors++; $display("FAIL rst_mid_col got %0d exp 0", out_col); end
        checks++; if (out_row !== '0) begin errors++; $display("FAIL rst_mid_row got %0d exp 0", out_row); end
        @(negedge clk) resetn = 1'b1;
        hub_addr = 5'd20;
        for (int c = 0; c < 64; c++) send_word(6'((c + 1) % 64));
        send_st();
        collect(0, 0, 300);
        checks++; if (n != 64) begin errors++; $display("FAIL rst_fresh_count got %0d exp 64", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g_col[k] !== 8'(k)) begin errors++; $display("FAIL rst_fresh_col[%0d] got %0d exp %0d", k, g_col[k], k); end
            checks++; if (g_rgb[k] !== 6'((k + 1) % 64)) begin errors++; $display("FAIL rst_fresh_rgb[%0d] got %0d exp %0d", k, g_rgb[k], (k + 1) % 64); end
        end
        checks++; if (g_row[0] !== 5'd20) begin errors++; $display("FAIL rst_fresh_row got %0d exp 20", g_row[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_col_err();
        test_backpressure();
        test_overrun();
        test_oe_meter();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
